// File: rtl/udp_frame_packer_if.sv
// ============================================================================
// Module      : udp_frame_packer_if
// Description : Sample input, stream output and status bundle for
//               udp_frame_packer. The slave view belongs to the packer and
//               the master view to whatever feeds samples and consumes frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface udp_frame_packer_if #(
  parameter int DATA_W = 32
);
  // sample side
  logic              i_enable;
  logic [DATA_W-1:0] i_sample_data;
  logic              i_sample_valid;
  // stream side (udp_top wr_* port)
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_last;
  logic              i_ready;
  // status
  logic [31:0]       o_frame_cnt;
  logic [15:0]       o_drop_cnt;
  logic              o_busy;

  modport slave (
    input  i_enable, i_sample_data, i_sample_valid, i_ready,
    output o_data, o_valid, o_last, o_frame_cnt, o_drop_cnt, o_busy
  );

  modport master (
    output i_enable, i_sample_data, i_sample_valid, i_ready,
    input  o_data, o_valid, o_last, o_frame_cnt, o_drop_cnt, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/udp_frame_packer.sv
// ============================================================================
// Module      : udp_frame_packer
// Description : Buffers ADC samples in a small FIFO and emits fixed-length
//               frames (one header word + FRAME_LEN payload words) on a
//               valid/ready stream. Counts sent frames and dropped samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_frame_packer #(
  parameter int          DATA_W     = 32,
  parameter int          FRAME_LEN  = 10,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] MAGIC      = 16'hA55A
) (
  input  logic               i_Sys_clk,
  input  logic               i_Rst_n,
  udp_frame_packer_if.slave  bus
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_LW = $clog2(FRAME_LEN + 1);

  localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_FLEN_OCC  = c_CW'(FRAME_LEN);
  localparam logic [c_LW-1:0] c_FLEN_WORD = c_LW'(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;
  logic [c_LW-1:0]   r_word_cnt;
  logic [15:0]       r_seq;
  logic [31:0]       r_frame_cnt;
  logic [15:0]       r_drop_cnt;

  logic              w_xfer;
  logic              w_full;
  logic              w_push_req;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_load_hdr;
  logic              w_done;
  logic [c_LW-1:0]   w_word_nxt;
  logic [DATA_W-1:0] w_hdr;

  assign w_xfer     = r_valid & bus.i_ready;
  assign w_full     = (r_count == c_DEPTH);
  assign w_push_req = bus.i_enable & bus.i_sample_valid;
  // A full FIFO still accepts a sample when a word leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_word_nxt = r_word_cnt + c_LW'(1);

  // Header word: zero-extended {MAGIC, sequence number}.
  always_comb begin
    w_hdr       = '0;
    w_hdr[31:0] = {MAGIC, r_seq};
  end

  // Frame sequencing: decide when to load the header, pop payload, finish.
  always_comb begin
    w_state_nxt = r_state;
    w_load_hdr  = 1'b0;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Only start once the whole payload is buffered, so PAY never starves.
        if (bus.i_enable && (r_count >= c_FLEN_OCC)) begin
          w_state_nxt = ST_HDR;
          w_load_hdr  = 1'b1;
        end
      end
      ST_HDR: begin
        if (w_xfer) begin
          w_state_nxt = ST_PAY;
          w_pop       = 1'b1;
        end
      end
      ST_PAY: begin
        if (w_xfer) begin
          if (r_word_cnt == c_FLEN_WORD) begin
            w_state_nxt = ST_IDLE;
            w_done      = 1'b1;
          end else begin
            w_pop = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge i_Sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.i_sample_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

  // Registered stream output plus frame/sequence bookkeeping.
  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_word_cnt  <= '0;
      r_seq       <= '0;
      r_frame_cnt <= '0;
    end else if (w_load_hdr) begin
      r_data     <= w_hdr;
      r_valid    <= 1'b1;
      r_last     <= 1'b0;
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_data     <= r_mem[r_rd_ptr];
      r_last     <= (w_word_nxt == c_FLEN_WORD);
      r_word_cnt <= w_word_nxt;
    end else if (w_done) begin
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_seq       <= r_seq + 16'd1;
      r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  // Saturating count of samples lost to overflow.
  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n)                            r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign bus.o_data      = r_data;
  assign bus.o_valid     = r_valid;
  assign bus.o_last      = r_last;
  assign bus.o_frame_cnt = r_frame_cnt;
  assign bus.o_drop_cnt  = r_drop_cnt;
  assign bus.o_busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_udp_frame_packer.sv
// ============================================================================
// Module      : tb_udp_frame_packer
// Description : Self-checking bench for udp_frame_packer. A queue-based frame
//               model predicts the stream, counters and busy flag every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_udp_frame_packer;

  localparam int          DATA_W     = 32;
  localparam int          FRAME_LEN  = 10;
  localparam int          FIFO_DEPTH = 16;
  localparam logic [15:0] MAGIC      = 16'hA55A;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  udp_frame_packer_if #(.DATA_W(DATA_W)) bus ();

  udp_frame_packer #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MAGIC     (MAGIC)
  ) dut (
    .i_Sys_clk(clk),
    .i_Rst_n  (rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_pos: -1 idle, 0 header on the bus, k = payload word k (1-based) on the bus
  logic [DATA_W-1:0] mq[$];
  int                m_pos;
  bit                m_valid;
  bit                m_last;
  logic [DATA_W-1:0] m_data;
  logic [15:0]       m_seq;
  logic [31:0]       m_frames;
  logic [15:0]       m_drops;

  task automatic model_reset();
    mq.delete();
    m_pos    = -1;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_data   = '0;
    m_seq    = '0;
    m_frames = '0;
    m_drops  = '0;
  endtask

  // Advance the model by one clock edge using the inputs held during the cycle.
  task automatic model_update();
    bit                xfer;
    bit                start;
    bit                pop;
    bit                was_full;
    logic [DATA_W-1:0] popped;
    if (!rst_n) begin
      model_reset();
      return;
    end
    xfer     = m_valid && bus.i_ready;
    start    = (m_pos < 0) && bus.i_enable && (mq.size() >= FRAME_LEN);
    pop      = xfer && (m_pos < FRAME_LEN);
    was_full = (mq.size() == FIFO_DEPTH);
    popped   = '0;
    if (pop) popped = mq.pop_front();
    if (bus.i_enable && bus.i_sample_valid) begin
      if (was_full && !pop) begin
        if (m_drops != 16'hFFFF) m_drops++;
      end else begin
        mq.push_back(bus.i_sample_data);
      end
    end
    if (start) begin
      m_pos        = 0;
      m_valid      = 1'b1;
      m_last       = 1'b0;
      m_data       = '0;
      m_data[31:0] = {MAGIC, m_seq};
    end else if (xfer) begin
      if (m_pos == FRAME_LEN) begin
        m_pos   = -1;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_seq++;
        m_frames++;
      end else begin
        m_pos++;
        m_data = popped;
        m_last = (m_pos == FRAME_LEN);
      end
    end
  endtask

  task automatic compare();
    chk("valid", 64'(bus.o_valid), 64'(m_valid));
    chk("busy", 64'(bus.o_busy), 64'(m_pos >= 0));
    chk("frame_cnt", 64'(bus.o_frame_cnt), 64'(m_frames));
    chk("drop_cnt", 64'(bus.o_drop_cnt), 64'(m_drops));
    if (m_valid) begin
      chk("data", 64'(bus.o_data), 64'(m_data));
      chk("last", 64'(bus.o_last), 64'(m_last));
    end
  endtask

  // One clock: edge, model update, then check on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input bit en, input bit sv, input logic [DATA_W-1:0] d, input bit rdy);
    bus.i_enable       = en;
    bus.i_sample_valid = sv;
    bus.i_sample_data  = d;
    bus.i_ready        = rdy;
    step();
  endtask

  task automatic idle(input int n, input bit en, input bit rdy);
    for (int i = 0; i < n; i++) drive(en, 1'b0, '0, rdy);
  endtask

  task automatic wait_pos(input string tag, input int pos, input bit en, input bit rdy);
    int k;
    k = 0;
    while (m_pos != pos && k < 200) begin
      drive(en, 1'b0, '0, rdy);
      k++;
    end
    chk(tag, 64'(m_pos == pos), 64'd1);
  endtask

  initial begin
    model_reset();
    bus.i_enable       = 1'b0;
    bus.i_sample_valid = 1'b0;
    bus.i_sample_data  = '0;
    bus.i_ready        = 1'b0;

    // reset state
    idle(3, 1'b0, 1'b0);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    rst_n = 1'b1;
    idle(2, 1'b1, 1'b1);

    // 1: slow samples, single frame
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b1, DATA_W'(i), 1'b1);
      idle(46, 1'b1, 1'b1);
    end
    idle(20, 1'b1, 1'b1);
    chk("s1_frames", 64'(bus.o_frame_cnt), 64'd1);
    chk("s1_drops", 64'(bus.o_drop_cnt), 64'd0);

    // 2: twenty back-to-back samples, two frames
    for (int i = 1; i <= 20; i++) drive(1'b1, 1'b1, DATA_W'(i), 1'b1);
    idle(60, 1'b1, 1'b1);
    chk("s2_frames", 64'(bus.o_frame_cnt), 64'd3);

    // 3: ready pattern 1,0,0,1
    for (int i = 0; i < 90; i++)
      drive(1'b1, i < 10, DATA_W'(i + 1), (i % 4 == 0) || (i % 4 == 3));
    chk("s3_frames", 64'(bus.o_frame_cnt), 64'd4);

    // 4: overflow while stalled
    for (int i = 1; i <= 20; i++) drive(1'b1, 1'b1, DATA_W'(100 + i), 1'b0);
    chk("s4_drops", 64'(bus.o_drop_cnt), 64'd4);
    idle(40, 1'b1, 1'b1);
    chk("s4_frames", 64'(bus.o_frame_cnt), 64'd5);
    chk("s4_waiting", 64'(bus.o_busy), 64'd0);
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b1, DATA_W'(200 + i), 1'b1);
    idle(30, 1'b1, 1'b1);
    chk("s4_frames2", 64'(bus.o_frame_cnt), 64'd6);

    // 5: enable drops after payload word 3
    for (int i = 1; i <= 10; i++) drive(1'b1, 1'b1, DATA_W'(300 + i), 1'b1);
    wait_pos("s5_reach", 4, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, DATA_W'(400 + i), 1'b1);
    chk("s5_frames", 64'(bus.o_frame_cnt), 64'd7);
    chk("s5_drops", 64'(bus.o_drop_cnt), 64'd4);
    idle(15, 1'b1, 1'b1);
    chk("s5_no_hdr", 64'(bus.o_busy), 64'd0);

    // 6: asynchronous reset mid-payload
    for (int i = 1; i <= 10; i++) drive(1'b1, 1'b1, DATA_W'(500 + i), 1'b1);
    wait_pos("s6_reach", 5, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("s6_valid", 64'(bus.o_valid), 64'd0);
    chk("s6_last", 64'(bus.o_last), 64'd0);
    chk("s6_frames", 64'(bus.o_frame_cnt), 64'd0);
    chk("s6_drops", 64'(bus.o_drop_cnt), 64'd0);
    chk("s6_busy", 64'(bus.o_busy), 64'd0);
    model_reset();
    idle(2, 1'b1, 1'b1);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) drive(1'b1, 1'b1, DATA_W'(600 + i), 1'b1);
    wait_pos("s6_hdr_reach", 0, 1'b1, 1'b1);
    chk("s6_hdr", 64'(bus.o_data), 64'h0000_0000_A55A_0000);
    idle(20, 1'b1, 1'b1);
    chk("s6_frames2", 64'(bus.o_frame_cnt), 64'd1);

    // randomized traffic at several ready/sample densities
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        drive($urandom_range(0, 15) != 0,
              $urandom_range(0, 3) <= ph,
              DATA_W'($urandom),
              $urandom_range(0, 3) >= ph);
      end
    end
    idle(100, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
